// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: shared types for the cluster icache, including the flush sequencer FSM states
package snitch_icache_pkg;
    typedef enum logic [1:0] {
        IDLE,
        L0,
        L1,
        DONE
    } flush_seq_state_e;
endpackage

// File: rtl/cluster_icache_flush_sequencer.sv
// cluster_icache_flush_sequencer: captures per-port flush requests, flushes the requested L0s, optionally L1, then acks them together
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_valid_i     per-port flush request (held until flush_ready_o), flush_l1_i sampled with it
//   flush_ready_o     one-cycle ack to every captured requester
//   l0_flush_*        flush handshake towards each L0, l1_flush_* towards L1
//   busy_o            sequence in flight, flush_count_o completed sequences (wrapping)
module cluster_icache_flush_sequencer
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NR_FETCH_PORTS-1:0] flush_valid_i,
    input  logic                      flush_l1_i,
    output logic [NR_FETCH_PORTS-1:0] flush_ready_o,
    output logic [NR_FETCH_PORTS-1:0] l0_flush_valid_o,
    input  logic [NR_FETCH_PORTS-1:0] l0_flush_ready_i,
    output logic                      l1_flush_valid_o,
    input  logic                      l1_flush_ready_i,
    output logic                      busy_o,
    output logic [CNT_WIDTH-1:0]      flush_count_o
);
    flush_seq_state_e          state_q, state_d;
    logic [NR_FETCH_PORTS-1:0] pend_q, pend_d, ack_q, ack_d;
    logic                      l1_q, l1_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ack_q   <= '0;
            l1_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            l1_q    <= l1_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ack_d   = ack_q;
        l1_d    = l1_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (|flush_valid_i) begin
                pend_d  = flush_valid_i;
                ack_d   = flush_valid_i;
                l1_d    = flush_l1_i;
                state_d = L0;
            end
            L0: begin
                // readies on ports outside pend_q are masked out by the AND
                pend_d  = pend_q & ~l0_flush_ready_i;
                state_d = (pend_d == '0) ? (l1_q ? L1 : DONE) : L0;
            end
            L1: state_d = l1_flush_ready_i ? DONE : L1;
            DONE: begin
                count_d = count_q + CNT_WIDTH'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs decode only registered state, so no input reaches an output combinationally
    assign l0_flush_valid_o = (state_q == L0) ? pend_q : '0;
    assign l1_flush_valid_o = (state_q == L1);
    assign flush_ready_o    = (state_q == DONE) ? ack_q : '0;
    assign busy_o           = (state_q != IDLE);
    assign flush_count_o    = count_q;
endmodule

// File: tb/tb_cluster_icache_flush_sequencer.sv
// tb_cluster_icache_flush_sequencer: scoreboard bench for the icache flush sequencer
module tb_cluster_icache_flush_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] flush_valid_i;
    logic       flush_l1_i;
    logic [3:0] flush_ready_o;
    logic [3:0] l0_flush_valid_o;
    logic [3:0] l0_flush_ready_i;
    logic       l1_flush_valid_o;
    logic       l1_flush_ready_i;
    logic       busy_o;
    logic [1:0] flush_count_o;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [1:0] exp_count = 2'd0;

    cluster_icache_flush_sequencer #(.NR_FETCH_PORTS(4), .CNT_WIDTH(2)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_valid_i(flush_valid_i),
        .flush_l1_i(flush_l1_i),
        .flush_ready_o(flush_ready_o),
        .l0_flush_valid_o(l0_flush_valid_o),
        .l0_flush_ready_i(l0_flush_ready_i),
        .l1_flush_valid_o(l1_flush_valid_o),
        .l1_flush_ready_i(l1_flush_ready_i),
        .busy_o(busy_o),
        .flush_count_o(flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    // ack monitor: every nonzero flush_ready_o must match the oldest expected ack
    always @(negedge clk_i) begin
        if (!rst_i && flush_ready_o != 4'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: got %b, none expected", flush_ready_o);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (flush_ready_o !== e) begin
                    fails++;
                    $display("FAIL ack_mask: got %b, expected %b", flush_ready_o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_valid_i = '0;
        flush_l1_i = 1'b0;
        l0_flush_ready_i = '0;
        l1_flush_ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        exp_count = 2'd0;
    endtask

    // one L0-only sequence with immediate readies, checked cycle by cycle
    task automatic run_simple(input logic [3:0] m);
        flush_valid_i = m;
        flush_l1_i = 1'b0;
        exp_q.push_back(m);
        step();
        chk("simple_l0_valid", 32'(l0_flush_valid_o), 32'(m));
        l0_flush_ready_i = m;
        step();
        chk("simple_ack", 32'(flush_ready_o), 32'(m));
        l0_flush_ready_i = '0;
        flush_valid_i = '0;
        exp_count = exp_count + 2'd1;
        step();
        chk("simple_count", 32'(flush_count_o), 32'(exp_count));
        chk("simple_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic test_reset();
        do_reset();
        flush_valid_i = 4'b0110;
        step();
        step();
        chk("rst_pre_l0_valid", 32'(l0_flush_valid_o), 32'b0110);
        rst_i = 1'b1;
        repeat (3) step();
        chk("rst_l0_valid", 32'(l0_flush_valid_o), 32'd0);
        chk("rst_l1_valid", 32'(l1_flush_valid_o), 32'd0);
        chk("rst_ready", 32'(flush_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_count", 32'(flush_count_o), 32'd0);
        flush_valid_i = '0;
        rst_i = 1'b0;
        step();
        step();
        chk("rst_stays_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic test_l0_only();
        flush_valid_i = 4'b0101;
        flush_l1_i = 1'b0;
        exp_q.push_back(4'b0101);
        chk("l0o_no_comb_path", 32'(l0_flush_valid_o), 32'd0);
        step();
        chk("l0o_l0_valid", 32'(l0_flush_valid_o), 32'b0101);
        chk("l0o_l1_valid_t1", 32'(l1_flush_valid_o), 32'd0);
        chk("l0o_busy", 32'(busy_o), 32'd1);
        l0_flush_ready_i = 4'b0101;
        step();
        chk("l0o_ack", 32'(flush_ready_o), 32'b0101);
        chk("l0o_l0_dropped", 32'(l0_flush_valid_o), 32'd0);
        chk("l0o_l1_valid_t2", 32'(l1_flush_valid_o), 32'd0);
        l0_flush_ready_i = '0;
        flush_valid_i = '0;
        exp_count = exp_count + 2'd1;
        step();
        chk("l0o_count", 32'(flush_count_o), 32'(exp_count));
        chk("l0o_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic test_staggered_l1();
        logic [3:0] rdy[5] = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0110};
        logic [3:0] vld[5] = '{4'b1111, 4'b1110, 4'b1110, 4'b0110, 4'b0110};
        flush_valid_i = 4'b1111;
        flush_l1_i = 1'b1;
        exp_q.push_back(4'b1111);
        for (int i = 0; i < 5; i++) begin
            step();
            flush_l1_i = 1'b0;
            chk("stg_l0_valid", 32'(l0_flush_valid_o), 32'(vld[i]));
            chk("stg_l1_early", 32'(l1_flush_valid_o), 32'd0);
            l0_flush_ready_i = rdy[i];
        end
        for (int i = 0; i < 4; i++) begin
            step();
            l0_flush_ready_i = '0;
            chk("stg_l1_valid", 32'(l1_flush_valid_o), 32'd1);
            chk("stg_no_l0", 32'(l0_flush_valid_o), 32'd0);
            chk("stg_no_ack", 32'(flush_ready_o), 32'd0);
            l1_flush_ready_i = (i == 3);
        end
        step();
        chk("stg_ack", 32'(flush_ready_o), 32'b1111);
        chk("stg_l1_dropped", 32'(l1_flush_valid_o), 32'd0);
        l1_flush_ready_i = 1'b0;
        flush_valid_i = '0;
        exp_count = exp_count + 2'd1;
        step();
        chk("stg_count", 32'(flush_count_o), 32'(exp_count));
        chk("stg_single_ack", 32'(flush_ready_o), 32'd0);
    endtask

    task automatic test_request_during_l1();
        flush_valid_i = 4'b0001;
        flush_l1_i = 1'b1;
        exp_q.push_back(4'b0001);
        step();
        l0_flush_ready_i = 4'b0001;
        step();
        l0_flush_ready_i = '0;
        chk("ovl_l1_valid", 32'(l1_flush_valid_o), 32'd1);
        flush_valid_i = 4'b0011;
        flush_l1_i = 1'b0;
        step();
        chk("ovl_l1_wait", 32'(l1_flush_valid_o), 32'd1);
        l1_flush_ready_i = 1'b1;
        step();
        l1_flush_ready_i = 1'b0;
        chk("ovl_first_ack", 32'(flush_ready_o), 32'b0001);
        flush_valid_i = 4'b0010;
        exp_q.push_back(4'b0010);
        exp_count = exp_count + 2'd1;
        step();
        chk("ovl_idle_gap", 32'(busy_o), 32'd0);
        step();
        chk("ovl_second_l0", 32'(l0_flush_valid_o), 32'b0010);
        l0_flush_ready_i = 4'b0010;
        step();
        l0_flush_ready_i = '0;
        chk("ovl_second_ack", 32'(flush_ready_o), 32'b0010);
        flush_valid_i = '0;
        exp_count = exp_count + 2'd1;
        step();
        chk("ovl_count", 32'(flush_count_o), 32'(exp_count));
    endtask

    task automatic test_spurious_ready();
        flush_valid_i = 4'b0001;
        flush_l1_i = 1'b0;
        exp_q.push_back(4'b0001);
        step();
        l0_flush_ready_i = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur_l0_held", 32'(l0_flush_valid_o), 32'b0001);
            chk("spur_no_ack", 32'(flush_ready_o), 32'd0);
        end
        l0_flush_ready_i = 4'b0001;
        step();
        l0_flush_ready_i = '0;
        chk("spur_ack", 32'(flush_ready_o), 32'b0001);
        flush_valid_i = '0;
        exp_count = exp_count + 2'd1;
        step();
        chk("spur_count", 32'(flush_count_o), 32'(exp_count));
    endtask

    task automatic test_counter_wrap();
        logic [3:0] masks[5] = '{4'b0001, 4'b1000, 4'b0110, 4'b1111, 4'b0100};
        do_reset();
        for (int i = 0; i < 5; i++) run_simple(masks[i]);
        chk("wrap_count", 32'(flush_count_o), 32'd1);
    endtask

    initial begin
        test_reset();
        test_l0_only();
        test_staggered_l1();
        test_request_during_l1();
        test_spurious_ready();
        test_counter_wrap();
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
